// File: rtl/loa_error_scanner_pkg.sv
// Shared types and width helpers for the loaAdder error scanner.
package loa_pkg;

  localparam int unsigned DEF_N = 4;
  localparam int unsigned DEF_K = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return 2 * n;
  endfunction

  function automatic int unsigned res_w(input int unsigned n);
    return n + 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/loa_error_scanner_adder.sv
// Lower-part OR adder: low K bits are ORed, the upper part adds exactly with
// a carry-in guessed from the AND of the top approximate bit pair.
module loaAdder #(
  parameter int unsigned N = 4,
  parameter int unsigned K = 2
) (
  input  logic [N-1:0] i_A,
  input  logic [N-1:0] i_B,
  output logic [N-1:0] o_Sum,
  output logic         o_Cout
);

  if (K == 0) begin : g_exact
    assign {o_Cout, o_Sum} = {1'b0, i_A} + {1'b0, i_B};
  end else if (K >= N) begin : g_all_or
    assign o_Sum  = i_A | i_B;
    assign o_Cout = i_A[N-1] & i_B[N-1];
  end else begin : g_split
    logic [N-K:0] hi;
    assign hi     = {1'b0, i_A[N-1:K]} + {1'b0, i_B[N-1:K]}
                  + {{(N-K){1'b0}}, i_A[K-1] & i_B[K-1]};
    assign o_Sum  = {hi[N-K-1:0], i_A[K-1:0] | i_B[K-1:0]};
    assign o_Cout = hi[N-K];
  end

endmodule

// File: rtl/loa_error_scanner.sv
// Sweeps every {A,B} pair through loaAdder, accumulates mismatch statistics
// and streams each mismatching vector out through a one-entry record slot.
module loa_error_scanner
  import loa_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned K = DEF_K
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Start,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [cnt_w(N)-1:0]   o_ErrCount,
  output logic [res_w(N)-1:0]   o_MaxErr,
  output logic                  o_ErrValid,
  input  logic                  i_ErrReady,
  output logic [N-1:0]          o_ErrA,
  output logic [N-1:0]          o_ErrB,
  output logic [res_w(N)-1:0]   o_ErrApprox,
  output logic [res_w(N)-1:0]   o_ErrExact
);

  localparam int unsigned IDX_W = idx_w(N);
  localparam int unsigned RES_W = res_w(N);

  typedef struct packed {
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [RES_W-1:0] approx;
    logic [RES_W-1:0] exact;
  } rec_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             s1_valid;
  rec_t             s1;

  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic [N-1:0]     loa_sum;
  logic             loa_cout;
  logic [RES_W-1:0] exact;
  logic [RES_W-1:0] approx;
  logic [RES_W-1:0] diff;
  logic             mismatch;
  logic             stall;

  assign op_a = idx[IDX_W-1:N];
  assign op_b = idx[N-1:0];

  loaAdder #(
    .N(N),
    .K(K)
  ) u_loa (
    .i_A   (op_a),
    .i_B   (op_b),
    .o_Sum (loa_sum),
    .o_Cout(loa_cout)
  );

  always_comb begin
    exact    = {1'b0, op_a} + {1'b0, op_b};
    approx   = {loa_cout, loa_sum};
    mismatch = s1_valid && (s1.approx != s1.exact);
    // A mismatch can only retire if the slot is empty or being drained now.
    stall    = mismatch && o_ErrValid && !i_ErrReady;
    diff     = (s1.exact > s1.approx) ? (s1.exact - s1.approx) : (s1.approx - s1.exact);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      s1_valid    <= 1'b0;
      s1          <= '0;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
      o_ErrCount  <= '0;
      o_MaxErr    <= '0;
      o_ErrValid  <= 1'b0;
      o_ErrA      <= '0;
      o_ErrB      <= '0;
      o_ErrApprox <= '0;
      o_ErrExact  <= '0;
    end else begin
      o_Done <= 1'b0;
      if (o_ErrValid && i_ErrReady) o_ErrValid <= 1'b0;

      if (mismatch && !stall) begin
        o_ErrCount  <= o_ErrCount + 1'b1;
        if (diff > o_MaxErr) o_MaxErr <= diff;
        o_ErrValid  <= 1'b1;
        o_ErrA      <= s1.a;
        o_ErrB      <= s1.b;
        o_ErrApprox <= s1.approx;
        o_ErrExact  <= s1.exact;
      end

      if (!stall) s1_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (i_Start) begin
            state      <= RUN;
            o_Busy     <= 1'b1;
            idx        <= '0;
            o_ErrCount <= '0;
            o_MaxErr   <= '0;
          end
        end
        RUN: begin
          if (!stall) begin
            s1_valid <= 1'b1;
            s1       <= {op_a, op_b, approx, exact};
            idx      <= idx + 1'b1;
            if (idx == '1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_valid && !o_ErrValid) begin
            state  <= DONE;
            o_Busy <= 1'b0;
            o_Done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loa_error_scanner.sv
// Bench for loa_error_scanner: K=2 and K=0 instances, records scoreboarded
// against a behavioural lower-part-OR model.
module tb_loa_error_scanner;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] approx;
    logic [4:0] exact;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start2 = 1'b0;
  logic       ready2 = 1'b1;
  logic       start0 = 1'b0;
  logic       ready0 = 1'b1;

  logic       busy2, done2, valid2;
  logic [8:0] cnt2;
  logic [4:0] max2, eap2, eex2;
  logic [3:0] ea2, eb2;

  logic       busy0, done0, valid0;
  logic [8:0] cnt0;
  logic [4:0] max0, eap0, eex0;
  logic [3:0] ea0, eb0;

  int checks = 0;
  int errors = 0;
  rec_t q[$];

  always #5 clk = ~clk;

  loa_error_scanner #(.N(4), .K(2)) dut2 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start2), .o_Busy(busy2), .o_Done(done2),
    .o_ErrCount(cnt2), .o_MaxErr(max2), .o_ErrValid(valid2), .i_ErrReady(ready2),
    .o_ErrA(ea2), .o_ErrB(eb2), .o_ErrApprox(eap2), .o_ErrExact(eex2)
  );

  loa_error_scanner #(.N(4), .K(0)) dut0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start0), .o_Busy(busy0), .o_Done(done0),
    .o_ErrCount(cnt0), .o_MaxErr(max0), .o_ErrValid(valid0), .i_ErrReady(ready0),
    .o_ErrA(ea0), .o_ErrB(eb0), .o_ErrApprox(eap0), .o_ErrExact(eex0)
  );

  function automatic logic [4:0] loa_ref(input logic [3:0] a, input logic [3:0] b, input int k);
    logic [3:0] mask;
    logic [4:0] hi;
    logic       carry;
    if (k == 0) return {1'b0, a} + {1'b0, b};
    mask  = 4'((5'd1 << k) - 5'd1);
    carry = a[k-1] & b[k-1];
    hi    = {1'b0, a & ~mask} + {1'b0, b & ~mask} + (5'(carry) << k);
    return hi | {1'b0, (a | b) & mask};
  endfunction

  task automatic fill_queue(input int k);
    q.delete();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      rec_t r;
      v        = i[7:0];
      r.a      = v[7:4];
      r.b      = v[3:0];
      r.approx = loa_ref(r.a, r.b, k);
      r.exact  = {1'b0, r.a} + {1'b0, r.b};
      if (r.approx != r.exact) q.push_back(r);
    end
  endtask

  // Runs one sweep of the K=2 instance; rel counts edges after the start edge.
  task automatic sweep2(input int stall_len, input int restart_at, input int abort_at,
                        output int done_rel, output int nrec, output bit aborted);
    int   rel;
    int   stall_left;
    bit   first_seen;
    rec_t front;
    rel = 0; stall_left = 0; first_seen = 0; done_rel = -1; nrec = 0; aborted = 0;
    @(negedge clk); start2 = 1'b1; ready2 = 1'b1;
    @(posedge clk);
    @(negedge clk); start2 = 1'b0;
    checks++;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL busy_rise: got %0b expected 1", busy2); end
    while (done_rel < 0 && rel < 2000) begin
      if (done2 === 1'b1) done_rel = rel;
      if (valid2 === 1'b1 && !first_seen) begin
        first_seen = 1;
        checks++;
        if (rel != 19 || ea2 !== 4'd1 || eb2 !== 4'd1 || eex2 !== 5'd2 || eap2 !== 5'd1) begin
          errors++;
          $display("FAIL first_record: got rel=%0d a=%0d b=%0d ex=%0d ap=%0d expected rel=19 a=1 b=1 ex=2 ap=1",
                   rel, ea2, eb2, eex2, eap2);
        end
        if (stall_len > 0) stall_left = stall_len + 1;
      end
      ready2 = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (!ready2) begin
        checks++;
        if (cnt2 !== 9'd1) begin errors++; $display("FAIL stall_count_frozen: got %0d expected 1", cnt2); end
      end
      if (valid2 === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_record: got a=%0d b=%0d expected no record", ea2, eb2);
        end else begin
          front = q[0];
          checks++;
          if ({ea2, eb2, eap2, eex2} !== front) begin
            errors++;
            $display("FAIL record: got a=%0d b=%0d ap=%0d ex=%0d expected a=%0d b=%0d ap=%0d ex=%0d",
                     ea2, eb2, eap2, eex2, front.a, front.b, front.approx, front.exact);
          end
          if (ready2) begin void'(q.pop_front()); nrec++; end
        end
      end
      start2 = (rel + 1 == restart_at);
      if (rel + 1 == abort_at) begin
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
        checks++;
        if ({busy2, done2, cnt2, max2, valid2, ea2, eb2, eap2, eex2} !== '0) begin
          errors++;
          $display("FAIL abort_outputs_zero: got busy=%0b done=%0b cnt=%0d max=%0d valid=%0b a=%0d b=%0d ap=%0d ex=%0d expected all 0",
                   busy2, done2, cnt2, max2, valid2, ea2, eb2, eap2, eex2);
        end
        return;
      end
      if (done_rel < 0) begin
        @(posedge clk);
        @(negedge clk);
        rel++;
      end
    end
    start2 = 1'b0;
    ready2 = 1'b1;
    if (done_rel < 0) begin
      checks++; errors++;
      $display("FAIL sweep_timeout: got no done after %0d cycles expected done", rel);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy2, done2, cnt2, max2, valid2, ea2, eb2, eap2, eex2} !== '0) begin
      errors++; $display("FAIL reset_k2: got cnt=%0d max=%0d valid=%0b expected 0", cnt2, max2, valid2);
    end
    checks++;
    if ({busy0, done0, cnt0, max0, valid0, ea0, eb0, eap0, eex0} !== '0) begin
      errors++; $display("FAIL reset_k0: got cnt=%0d max=%0d valid=%0b expected 0", cnt0, max0, valid0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full_sweep();
    int done_rel, nrec;
    bit ab;
    fill_queue(2);
    sweep2(0, -1, -1, done_rel, nrec, ab);
    checks++;
    if (done_rel != 259) begin errors++; $display("FAIL full_done_cycle: got %0d expected 259", done_rel); end
    checks++;
    if (nrec != 112) begin errors++; $display("FAIL full_records: got %0d expected 112", nrec); end
    checks++;
    if (cnt2 !== 9'd112 || max2 !== 5'd2) begin
      errors++; $display("FAIL full_stats: got cnt=%0d max=%0d expected cnt=112 max=2", cnt2, max2);
    end
    checks++;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL busy_fall: got %0b expected 0", busy2); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done2 !== 1'b0 || cnt2 !== 9'd112) begin
      errors++; $display("FAIL done_one_cycle: got done=%0b cnt=%0d expected done=0 cnt=112", done2, cnt2);
    end
  endtask

  task automatic test_exact_k0();
    int rel = 0;
    int nvalid = 0;
    int done_rel = -1;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk);
    @(negedge clk); start0 = 1'b0;
    while (done_rel < 0 && rel < 2000) begin
      if (valid0 === 1'b1) nvalid++;
      if (done0 === 1'b1) done_rel = rel;
      else begin
        @(posedge clk);
        @(negedge clk);
        rel++;
      end
    end
    checks++;
    if (done_rel != 258) begin errors++; $display("FAIL k0_done_cycle: got %0d expected 258", done_rel); end
    checks++;
    if (nvalid != 0 || cnt0 !== 9'd0 || max0 !== 5'd0) begin
      errors++; $display("FAIL k0_stats: got valid_cycles=%0d cnt=%0d max=%0d expected 0 0 0", nvalid, cnt0, max0);
    end
  endtask

  task automatic test_backpressure();
    int done_rel, nrec;
    bit ab;
    fill_queue(2);
    // Ready held low for 21 edges after the first record; 20 of them stall a pending mismatch.
    sweep2(20, -1, -1, done_rel, nrec, ab);
    checks++;
    if (done_rel != 279) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 279", done_rel); end
    checks++;
    if (nrec != 112 || cnt2 !== 9'd112 || max2 !== 5'd2) begin
      errors++; $display("FAIL stall_stats: got rec=%0d cnt=%0d max=%0d expected 112 112 2", nrec, cnt2, max2);
    end
  endtask

  task automatic test_restart_ignored();
    int done_rel, nrec;
    bit ab;
    fill_queue(2);
    sweep2(0, 50, -1, done_rel, nrec, ab);
    checks++;
    if (done_rel != 259 || nrec != 112 || cnt2 !== 9'd112) begin
      errors++; $display("FAIL restart_ignored: got done=%0d rec=%0d cnt=%0d expected 259 112 112", done_rel, nrec, cnt2);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int done_rel, nrec;
    bit ab;
    fill_queue(2);
    sweep2(0, -1, 100, done_rel, nrec, ab);
    checks++;
    if (!ab || done_rel >= 0) begin
      errors++; $display("FAIL abort_no_done: got aborted=%0b done_rel=%0d expected aborted=1 done_rel=-1", ab, done_rel);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
      errors++; $display("FAIL abort_stays_idle: got valid=%0b busy=%0b done=%0b expected 0 0 0", valid2, busy2, done2);
    end
    fill_queue(2);
    sweep2(0, -1, -1, done_rel, nrec, ab);
    checks++;
    if (done_rel != 259 || nrec != 112 || cnt2 !== 9'd112 || max2 !== 5'd2) begin
      errors++; $display("FAIL rerun_after_abort: got done=%0d rec=%0d cnt=%0d max=%0d expected 259 112 112 2",
                         done_rel, nrec, cnt2, max2);
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_exact_k0();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
